hdlc_tx_framer: RTL

//  Bit-serial HDLC transmit framer, the send side of the Rx channel's flag, abort and zero-removal checks.

---
 rtl/hdlc_tx_framer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/hdlc_tx_framer.sv
// Bit-serial HDLC transmit framer: start flag, zero-stuffed payload, optional
// CRC-16/X.25 FCS and end flag, with an abort sequence on request or underrun.
module hdlc_tx_framer #(
    parameter int FCS_EN    = 1,
    parameter int MAX_BYTES = 126
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       TxEN,
    input  logic       Tx_StartFrame,
    input  logic [7:0] Tx_Data,
    input  logic       Tx_DataValid,
    input  logic       Tx_Last,
    output logic       Tx_DataReady,
    input  logic       Tx_AbortFrame,
    output logic       Tx,
    output logic       Tx_ValidFrame,
    output logic       Tx_Done,
    output logic       Tx_AbortedTrans,
    output logic [7:0] Tx_ByteCount
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] START_FLAG = 3'd1;
    localparam logic [2:0] DATA       = 3'd2;
    localparam logic [2:0] FCS        = 3'd3;
    localparam logic [2:0] END_FLAG   = 3'd4;
    localparam logic [2:0] ABORT      = 3'd5;

    localparam logic [7:0] FLAG_SEQ  = 8'h7E;
    localparam logic [7:0] ABORT_SEQ = 8'hFE;
    localparam logic [7:0] MAX_CNT   = 8'(MAX_BYTES);

    logic [2:0]  state;
    logic [2:0]  bit_cnt;
    logic [7:0]  byte_reg;
    logic [7:0]  hold_reg;
    logic        hold_full;
    logic        hold_last;
    logic        last_accepted;
    logic        last_loaded;
    logic [2:0]  ones_cnt;
    logic        fcs_hi;
    logic [15:0] crc;

    logic        active;
    logic        boundary;
    logic [2:0]  bit_nxt;
    logic        nxt_bit;
    logic [2:0]  ones_inc;
    logic        stuff_now;
    logic        underrun;
    logic        go_abort;
    logic        xfer;
    logic        take_last;
    logic [15:0] crc_upd;

    function automatic logic [15:0] crc_next(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        end
        return r;
    endfunction

    // ones_cnt counts consecutive ones currently on the line, so a stuffed 0 is due when it reaches 5
    always_comb begin
        active       = (state == START_FLAG) || (state == DATA) || (state == FCS) || (state == END_FLAG);
        boundary     = (bit_cnt == 3'd7);
        bit_nxt      = bit_cnt + 3'd1;
        nxt_bit      = byte_reg[bit_nxt];
        ones_inc     = nxt_bit ? (ones_cnt + 3'd1) : 3'd0;
        stuff_now    = ((state == DATA) || (state == FCS)) && (ones_cnt == 3'd5);
        underrun     = boundary && !hold_full &&
                       ((state == START_FLAG) || ((state == DATA) && !stuff_now && !last_loaded));
        go_abort     = active && (Tx_AbortFrame || !TxEN || underrun);
        Tx_DataReady = ((state == START_FLAG) || (state == DATA)) && !hold_full &&
                       !last_accepted && (Tx_ByteCount < MAX_CNT);
        xfer         = Tx_DataValid && Tx_DataReady && !go_abort;
        take_last    = Tx_Last || (Tx_ByteCount == (MAX_CNT - 8'd1));
        crc_upd      = crc_next(crc, hold_reg);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state           <= IDLE;
            bit_cnt         <= 3'd0;
            byte_reg        <= 8'd0;
            hold_reg        <= 8'd0;
            hold_full       <= 1'b0;
            hold_last       <= 1'b0;
            last_accepted   <= 1'b0;
            last_loaded     <= 1'b0;
            ones_cnt        <= 3'd0;
            fcs_hi          <= 1'b0;
            crc             <= 16'hFFFF;
            Tx              <= 1'b1;
            Tx_ValidFrame   <= 1'b0;
            Tx_Done         <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
            Tx_ByteCount    <= 8'd0;
        end else begin
            Tx_Done         <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
            if (xfer) begin
                hold_reg      <= Tx_Data;
                hold_full     <= 1'b1;
                hold_last     <= take_last;
                last_accepted <= take_last;
                Tx_ByteCount  <= Tx_ByteCount + 8'd1;
            end
            if (go_abort) begin
                state           <= ABORT;
                byte_reg        <= ABORT_SEQ;
                bit_cnt         <= 3'd0;
                Tx              <= ABORT_SEQ[0];
                Tx_ValidFrame   <= 1'b0;
                Tx_AbortedTrans <= 1'b1;
                hold_full       <= 1'b0;
                last_accepted   <= 1'b0;
                ones_cnt        <= 3'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (Tx_StartFrame && TxEN) begin
                            state         <= START_FLAG;
                            byte_reg      <= FLAG_SEQ;
                            bit_cnt       <= 3'd0;
                            Tx            <= FLAG_SEQ[0];
                            Tx_ValidFrame <= 1'b1;
                            Tx_ByteCount  <= 8'd0;
                            crc           <= 16'hFFFF;
                            hold_full     <= 1'b0;
                            hold_last     <= 1'b0;
                            last_accepted <= 1'b0;
                            last_loaded   <= 1'b0;
                            ones_cnt      <= 3'd0;
                        end
                    end
                    START_FLAG, DATA: begin
                        if (stuff_now) begin
                            Tx       <= 1'b0;
                            ones_cnt <= 3'd0;
                        end else if (!boundary) begin
                            bit_cnt  <= bit_nxt;
                            Tx       <= nxt_bit;
                            ones_cnt <= ones_inc;
                        end else if ((state == DATA) && last_loaded) begin
                            bit_cnt <= 3'd0;
                            if (FCS_EN != 0) begin
                                state    <= FCS;
                                byte_reg <= ~crc[7:0];
                                fcs_hi   <= 1'b0;
                                Tx       <= ~crc[0];
                                ones_cnt <= (~crc[0]) ? (ones_cnt + 3'd1) : 3'd0;
                            end else begin
                                state    <= END_FLAG;
                                byte_reg <= FLAG_SEQ;
                                Tx       <= FLAG_SEQ[0];
                            end
                        end else begin
                            state       <= DATA;
                            byte_reg    <= hold_reg;
                            crc         <= crc_upd;
                            last_loaded <= hold_last;
                            hold_full   <= 1'b0;
                            bit_cnt     <= 3'd0;
                            Tx          <= hold_reg[0];
                            ones_cnt    <= (state == START_FLAG) ? {2'b00, hold_reg[0]} :
                                           (hold_reg[0] ? (ones_cnt + 3'd1) : 3'd0);
                        end
                    end
                    FCS: begin
                        if (stuff_now) begin
                            Tx       <= 1'b0;
                            ones_cnt <= 3'd0;
                        end else if (!boundary) begin
                            bit_cnt  <= bit_nxt;
                            Tx       <= nxt_bit;
                            ones_cnt <= ones_inc;
                        end else if (!fcs_hi) begin
                            byte_reg <= ~crc[15:8];
                            fcs_hi   <= 1'b1;
                            bit_cnt  <= 3'd0;
                            Tx       <= ~crc[8];
                            ones_cnt <= (~crc[8]) ? (ones_cnt + 3'd1) : 3'd0;
                        end else begin
                            state    <= END_FLAG;
                            byte_reg <= FLAG_SEQ;
                            bit_cnt  <= 3'd0;
                            Tx       <= FLAG_SEQ[0];
                        end
                    end
                    END_FLAG, ABORT: begin
                        if (!boundary) begin
                            bit_cnt <= bit_nxt;
                            Tx      <= nxt_bit;
                        end else begin
                            state         <= IDLE;
                            bit_cnt       <= 3'd0;
                            Tx            <= 1'b1;
                            Tx_ValidFrame <= 1'b0;
                            Tx_Done       <= (state == END_FLAG);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        Tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
